calc_key_sequencer: RTL and testbench
=====================================

// Module: calc_key_sequencer
// PURPOSE
//  Keypad-side command sequencer driving the 8-bit BCD calculator ALU.
//  - Collects two packed-BCD operands and one operator from a key stream.
//  - Presents the operands and a one-hot operation select to the ALU.
//  - Captures the ALU result and status into registers, then reports them to the display path.
//  - Sits between the keypad decoder and the ALU. It issues the ALU's inputs and consumes its outputs.
// PARAMETERS
//  NDIG   2  BCD digits per operand. Fixed at 2 to match the 8-bit ALU; other values unsupported.
// PORTS
//  clk         in   1   system clock; all state updates on rising edge
//  rst         in   1   reset, synchronous, active-high
//  key_valid   in   1   key_code valid this cycle
//  key_code    in   4   0-9 digit, A add, B sub, C mul, D div, E equals, F clear
//  key_ready   out  1   sequencer can accept a key this cycle
//  alu_a       out  8   operand A, packed BCD, registered
//  alu_b       out  8   operand B, packed BCD, registered
//  sel_add     out  1   one-hot op select to ALU, registered
//  sel_sub     out  1   "
//  sel_mul     out  1   "
//  sel_div     out  1   "
//  alu_result  in   16  ALU result (combinational from alu_a/alu_b/sel_*)
//  alu_status  in   1   ALU status (carry/borrow/overflow/div-by-zero)
//  res_valid   out  1   one-cycle pulse: res_data/res_status updated
//  res_data    out  16  captured result
//  res_status  out  1   captured status
//  err         out  1   high while in ERR state
//  disp_val    out  16  value for display, see below
// BEHAVIOUR
//  Reset values:
//  - state=ENTER_A; alu_a, alu_b, sel_*, res_data, res_status, res_valid, err, disp_val all 0.
//  - key_ready=1.
//  Handshake:
//  - A key is accepted only in a cycle with key_valid && key_ready.
//  - key_ready=0 only in EXEC. The source holds the key until it is accepted.
//  Clear key (F):
//  - Accepted in any state with key_ready=1.
//  - Same effect as reset, except res_data and res_status hold their values.
//  States and transitions (non-clear keys):
//  - ENTER_A
//    - digit: alu_a <= {alu_a[3:0],d} if fewer than 2 digits entered; a 3rd+ digit is accepted and dropped.
//    - op: latch the one-hot sel_*, clear alu_b and the B digit count, go to ENTER_B. An operator with no A digits uses A=0.
//    - equals: accepted, ignored.
//  - ENTER_B
//    - digit: shift into alu_b, same 2-digit rule as ENTER_A.
//    - op before any B digit: replaces sel_*.
//    - op after a B digit: ignored.
//    - equals: go to EXEC. Equals with no B digit uses B=0.
//  - EXEC (1 cycle)
//    - alu_a, alu_b and sel_* are stable and the ALU settles.
//    - At the end of the cycle: res_data <= alu_result; res_status <= alu_status.
//    - Next state: ERR if (sel_div && alu_b==0), else DONE.
//  - DONE
//    - digit: clear alu_a and sel_*, shift the digit into alu_a, go to ENTER_A.
//    - op: chain. alu_a <= res_data[7:0], latch the new sel_*, clear alu_b, go to ENTER_B.
//    - equals: re-execute with the same operands (to EXEC).
//  - ERR
//    - err=1; all keys except clear are accepted and dropped.
//  Latency:
//  - Equals accepted in cycle t -> EXEC in t+1 -> res_valid=1 in t+2 only.
//  - res_data and res_status are valid from t+2 and held until the next capture.
//  sel_* rules:
//  - Exactly one is high from operator entry until a new digit starts ENTER_A from DONE, or clear.
//  - All are 0 in ENTER_A.
//  disp_val:
//  - ENTER_A: {8'h00,alu_a}.
//  - ENTER_B: {8'h00,alu_b} after the first B digit, else {8'h00,alu_a}.
//  - EXEC and DONE: res_data.
//  - ERR: 16'hFFFF.
//  Status:
//  - Mul overflow or add carry: captured in res_status only, not an error.
//  Reset mid-operation:
//  - rst in any state, including EXEC, forces the reset values on the next edge.
//  - No res_valid pulse is emitted for an aborted EXEC.
// TESTING
//  1. Keys 1,2,A,3,4,E -> alu_a=0x12, alu_b=0x34, sel_add=1; 2 cycles after E: res_valid pulse, res_data=0x0046, res_status=0.
//  2. Keys 5,D,0,E -> ERR; err=1, res_data=0xFFFF, res_status=1, disp_val=0xFFFF; key 7 dropped; F -> err=0, alu_a=0.
//  3. Keys 1,2,3 -> alu_a=0x12 (3rd digit dropped), key_ready=1 every cycle.
//  4. Keys 7,A,B,2,E -> sel_sub=1 only, alu_a=0x07, alu_b=0x02, res_data=0x0005.
//  5. After test 1, keys A,1,0,E -> alu_a=0x46, alu_b=0x10, res_data=0x0056 (chaining).
//  6. Assert rst during EXEC -> next cycle all outputs 0, no res_valid; key_valid held high during EXEC is accepted only after EXEC.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// Keypad-side command sequencer for the 8-bit BCD calculator ALU: gathers two
// packed-BCD operands and an operator from keys, runs the ALU, captures its result.
module calc_key_sequencer #(
    parameter int NDIG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        sel_add,
    output logic        sel_sub,
    output logic        sel_mul,
    output logic        sel_div,
    input  logic [15:0] alu_result,
    input  logic        alu_status,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_status,
    output logic        err,
    output logic [15:0] disp_val
);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] DIG_MAX = 2'(NDIG);

    state_t     state;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    logic [3:0] sel;
    logic [3:0] op_sel;
    logic       accept;
    logic       is_digit;
    logic       is_op;
    logic       is_eq;
    logic       is_clr;

    assign key_ready = (state != EXEC);
    assign accept    = key_valid && key_ready;
    assign is_digit  = (key_code <= 4'd9);
    assign is_op     = (key_code >= 4'hA) && (key_code <= 4'hD);
    assign is_eq     = (key_code == 4'hE);
    assign is_clr    = (key_code == 4'hF);

    assign {sel_div, sel_mul, sel_sub, sel_add} = sel;
    assign err = (state == ERR);

    // sel is kept as {div, mul, sub, add}
    always_comb begin
        op_sel = 4'b0000;
        case (key_code)
            4'hA:    op_sel = 4'b0001;
            4'hB:    op_sel = 4'b0010;
            4'hC:    op_sel = 4'b0100;
            4'hD:    op_sel = 4'b1000;
            default: op_sel = 4'b0000;
        endcase
    end

    always_comb begin
        disp_val = 16'h0000;
        case (state)
            ENTER_A: disp_val = {8'h00, alu_a};
            ENTER_B: disp_val = (b_cnt != 2'd0) ? {8'h00, alu_b} : {8'h00, alu_a};
            EXEC:    disp_val = res_data;
            DONE:    disp_val = res_data;
            ERR:     disp_val = 16'hFFFF;
            default: disp_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENTER_A;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            a_cnt      <= 2'd0;
            b_cnt      <= 2'd0;
            sel        <= 4'b0000;
            res_data   <= 16'h0000;
            res_status <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            // Clear behaves like reset but keeps the last captured result
            if (accept && is_clr) begin
                state <= ENTER_A;
                alu_a <= 8'h00;
                alu_b <= 8'h00;
                a_cnt <= 2'd0;
                b_cnt <= 2'd0;
                sel   <= 4'b0000;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (accept && is_digit) begin
                            if (a_cnt < DIG_MAX) begin
                                alu_a <= {alu_a[3:0], key_code};
                                a_cnt <= a_cnt + 2'd1;
                            end
                        end else if (accept && is_op) begin
                            sel   <= op_sel;
                            alu_b <= 8'h00;
                            b_cnt <= 2'd0;
                            state <= ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (accept && is_digit) begin
                            if (b_cnt < DIG_MAX) begin
                                alu_b <= {alu_b[3:0], key_code};
                                b_cnt <= b_cnt + 2'd1;
                            end
                        end else if (accept && is_op) begin
                            if (b_cnt == 2'd0) begin
                                sel <= op_sel;
                            end
                        end else if (accept && is_eq) begin
                            state <= EXEC;
                        end
                    end
                    EXEC: begin
                        res_data   <= alu_result;
                        res_status <= alu_status;
                        res_valid  <= 1'b1;
                        state      <= (sel[3] && (alu_b == 8'h00)) ? ERR : DONE;
                    end
                    DONE: begin
                        if (accept && is_digit) begin
                            alu_a <= {4'h0, key_code};
                            a_cnt <= 2'd1;
                            sel   <= 4'b0000;
                            state <= ENTER_A;
                        end else if (accept && is_op) begin
                            // Chain: the previous result becomes operand A
                            alu_a <= res_data[7:0];
                            a_cnt <= DIG_MAX;
                            sel   <= op_sel;
                            alu_b <= 8'h00;
                            b_cnt <= 2'd0;
                            state <= ENTER_B;
                        end else if (accept && is_eq) begin
                            state <= EXEC;
                        end
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state <= ENTER_A;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: directed key sequences plus random
// key streams compared against a decimal, key-by-key reference model.
module tb_calc_key_sequencer;

    localparam int MA = 0;
    localparam int MB = 1;
    localparam int MD = 2;
    localparam int ME = 3;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        sel_add;
    logic        sel_sub;
    logic        sel_mul;
    logic        sel_div;
    logic [15:0] alu_result;
    logic        alu_status;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_status;
    logic        err;
    logic [15:0] disp_val;

    int total;
    int bad;

    int          ma;
    int          mb;
    int          na;
    int          nb;
    int          mop;
    int          mode;
    logic [15:0] mres;
    logic        mstat;

    calc_key_sequencer #(.NDIG(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .sel_add    (sel_add),
        .sel_sub    (sel_sub),
        .sel_mul    (sel_mul),
        .sel_div    (sel_div),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_status (res_status),
        .err        (err),
        .disp_val   (disp_val)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] bcd16(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Decimal ALU: returns {status, result}
    function automatic logic [16:0] alu_ref(input int a, input int b, input int op);
        int v;
        case (op)
            0: begin v = a + b; return {v > 99 ? 1'b1 : 1'b0, bcd16(v)}; end
            1: begin
                if (a >= b) return {1'b0, bcd16(a - b)};
                else        return {1'b1, bcd16(100 + a - b)};
            end
            2: begin v = a * b; return {v > 99 ? 1'b1 : 1'b0, bcd16(v)}; end
            3: begin
                if (b == 0) return {1'b1, 16'hFFFF};
                else        return {1'b0, bcd8(a % b), bcd8(a / b)};
            end
            default: return 17'h0;
        endcase
    endfunction

    function automatic logic [16:0] alu_fn(input logic [7:0] a8, input logic [7:0] b8, input logic [3:0] s);
        int a;
        int b;
        int op;
        a = int'(a8[7:4]) * 10 + int'(a8[3:0]);
        b = int'(b8[7:4]) * 10 + int'(b8[3:0]);
        case (s)
            4'b0001: op = 0;
            4'b0010: op = 1;
            4'b0100: op = 2;
            4'b1000: op = 3;
            default: op = -1;
        endcase
        if (op < 0) return 17'h0;
        return alu_ref(a, b, op);
    endfunction

    always_comb begin
        {alu_status, alu_result} = alu_fn(alu_a, alu_b, {sel_div, sel_mul, sel_sub, sel_add});
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic modelClear(input bit full);
        ma = 0; mb = 0; na = 0; nb = 0; mop = -1; mode = MA;
        if (full) begin
            mres  = 16'h0000;
            mstat = 1'b0;
        end
    endtask

    // Applies one accepted key to the model; ex reports that an execution follows
    task automatic modelKey(input logic [3:0] k, output bit ex);
        int d;
        ex = 1'b0;
        d  = int'(k);
        if (k == 4'hF) begin
            modelClear(1'b0);
            return;
        end
        case (mode)
            MA: begin
                if (d <= 9) begin
                    if (na < 2) begin ma = ma * 10 + d; na++; end
                end else if (d <= 13) begin
                    mop = d - 10; mb = 0; nb = 0; mode = MB;
                end
            end
            MB: begin
                if (d <= 9) begin
                    if (nb < 2) begin mb = mb * 10 + d; nb++; end
                end else if (d <= 13) begin
                    if (nb == 0) mop = d - 10;
                end else begin
                    ex = 1'b1;
                end
            end
            MD: begin
                if (d <= 9) begin
                    ma = d; na = 1; mop = -1; mode = MA;
                end else if (d <= 13) begin
                    ma = int'(mres[7:4]) * 10 + int'(mres[3:0]);
                    mop = d - 10; mb = 0; nb = 0; mode = MB;
                end else begin
                    ex = 1'b1;
                end
            end
            default: ;
        endcase
        if (ex) begin
            {mstat, mres} = alu_ref(ma, mb, mop);
            mode = (mop == 3 && mb == 0) ? ME : MD;
        end
    endtask

    task automatic checkState();
        logic [3:0]  esel;
        logic [15:0] edisp;
        esel = (mode == MA) ? 4'b0000 : 4'(1 << mop);
        case (mode)
            MA:      edisp = {8'h00, bcd8(ma)};
            MB:      edisp = (nb > 0) ? {8'h00, bcd8(mb)} : {8'h00, bcd8(ma)};
            MD:      edisp = mres;
            default: edisp = 16'hFFFF;
        endcase
        checkOutput("alu_a", alu_a, bcd8(ma));
        checkOutput("alu_b", alu_b, bcd8(mb));
        checkOutput("sel", {sel_div, sel_mul, sel_sub, sel_add}, esel);
        checkOutput("err", err, (mode == ME) ? 1 : 0);
        checkOutput("disp_val", disp_val, edisp);
        checkOutput("key_ready", key_ready, 1);
        checkOutput("res_data_hold", res_data, mres);
        checkOutput("res_status_hold", res_status, mstat);
    endtask

    task automatic applyStimulus(input logic [3:0] k);
        int waited;
        bit ex;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        waited    = 0;
        while (!key_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_key", key_ready, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        modelKey(k, ex);
        if (ex) begin
            checkOutput("exec_ready", key_ready, 0);
            checkOutput("exec_no_pulse", res_valid, 0);
            @(posedge clk);
            #1;
            checkOutput("res_valid", res_valid, 1);
            checkOutput("res_data", res_data, mres);
            checkOutput("res_status", res_status, mstat);
        end else begin
            checkOutput("no_pulse", res_valid, 0);
        end
        checkState();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_alu_a"}, alu_a, 0);
        checkOutput({tag, "_alu_b"}, alu_b, 0);
        checkOutput({tag, "_sel"}, {sel_div, sel_mul, sel_sub, sel_add}, 0);
        checkOutput({tag, "_res_data"}, res_data, 0);
        checkOutput({tag, "_res_status"}, res_status, 0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_disp"}, disp_val, 0);
        checkOutput({tag, "_ready"}, key_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ex;
        int r;
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        modelClear(1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        // 12 + 34
        applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'hA);
        applyStimulus(4'h3); applyStimulus(4'h4); applyStimulus(4'hE);
        checkOutput("t1_a", alu_a, 8'h12);
        checkOutput("t1_b", alu_b, 8'h34);
        checkOutput("t1_add", sel_add, 1);
        checkOutput("t1_res", res_data, 16'h0046);
        checkOutput("t1_stat", res_status, 0);

        // chaining on 46: +10
        applyStimulus(4'hA); applyStimulus(4'h1); applyStimulus(4'h0); applyStimulus(4'hE);
        checkOutput("t5_a", alu_a, 8'h46);
        checkOutput("t5_b", alu_b, 8'h10);
        checkOutput("t5_res", res_data, 16'h0056);

        // divide by zero
        applyStimulus(4'h5); applyStimulus(4'hD); applyStimulus(4'h0); applyStimulus(4'hE);
        checkOutput("t2_err", err, 1);
        checkOutput("t2_res", res_data, 16'hFFFF);
        checkOutput("t2_stat", res_status, 1);
        checkOutput("t2_disp", disp_val, 16'hFFFF);
        applyStimulus(4'h7);
        checkOutput("t2_drop", err, 1);
        applyStimulus(4'hF);
        checkOutput("t2_clr_err", err, 0);
        checkOutput("t2_clr_a", alu_a, 0);

        // third digit dropped
        applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'h3);
        checkOutput("t3_a", alu_a, 8'h12);
        applyStimulus(4'hF);

        // operator replacement before B digits
        applyStimulus(4'h7); applyStimulus(4'hA); applyStimulus(4'hB);
        applyStimulus(4'h2); applyStimulus(4'hE);
        checkOutput("t4_sel", {sel_div, sel_mul, sel_sub, sel_add}, 4'b0010);
        checkOutput("t4_a", alu_a, 8'h07);
        checkOutput("t4_b", alu_b, 8'h02);
        checkOutput("t4_res", res_data, 16'h0005);

        // key held through EXEC is taken only once EXEC ends
        applyStimulus(4'hF); applyStimulus(4'h1); applyStimulus(4'hA); applyStimulus(4'h2);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hE;
        @(posedge clk);
        #1;
        key_code = 4'h7;
        modelKey(4'hE, ex);
        checkOutput("hold_exec_ready", key_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("hold_pulse", res_valid, 1);
        checkOutput("hold_not_taken", alu_a, 8'h01);
        checkOutput("hold_res", res_data, 16'h0003);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        modelKey(4'h7, ex);
        checkOutput("hold_taken", alu_a, 8'h07);
        checkState();

        // reset during EXEC
        applyStimulus(4'hC); applyStimulus(4'h3);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hE;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        checkOutput("rst_exec_ready", key_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelClear(1'b1);
        checkResetValues("rst_exec");
        @(posedge clk);
        #1;
        checkOutput("rst_exec_no_pulse", res_valid, 0);

        // random key stream
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      applyStimulus(4'($urandom_range(0, 9)));
            else if (r < 75) applyStimulus(4'(10 + $urandom_range(0, 3)));
            else if (r < 93) applyStimulus(4'hE);
            else             applyStimulus(4'hF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
